// File: rtl/unibus_pkg.sv
// Shared definitions for the Unibus-style RAM responder.
//   state_t    : handshake FSM states (idle, wait-state countdown, ack held)
//   ADDR_W     : byte-address width of the request bus
//   DATA_W     : data width of the request bus and of a RAM word
//   lane_merge : merges new byte lanes into an existing word
package unibus_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  // Returns old_word with the enabled byte lanes replaced by new_word.
  function automatic logic [DATA_W-1:0] lane_merge(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic              we_lo,
    input logic              we_hi
  );
    logic [DATA_W-1:0] merged;
    merged = old_word;
    if (we_lo) merged[7:0]  = new_word[7:0];
    if (we_hi) merged[15:8] = new_word[15:8];
    return merged;
  endfunction

endpackage

// File: rtl/ram_bytelane.sv
// Single-port synchronous RAM, 2^AW words of DATA_W bits, byte-lane writes.
//   clk   : clock
//   idx   : word index
//   we_lo : write enable for bits [7:0]
//   we_hi : write enable for bits [15:8]
//   wdata : write data (each lane taken from its own position)
//   rdata : registered read data; on a write edge it returns the merged
//           (post-write) word so the caller can echo the written word
module ram_bytelane
  import unibus_pkg::*;
#(
  parameter int unsigned AW = 12
) (
  input  logic              clk,
  input  logic [AW-1:0]     idx,
  input  logic              we_lo,
  input  logic              we_hi,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (we_lo) r_mem[idx][7:0]  <= wdata[7:0];
    if (we_hi) r_mem[idx][15:8] <= wdata[15:8];
    rdata <= lane_merge(r_mem[idx], wdata, we_lo, we_hi);
  end

endmodule

// File: rtl/unibus_ram_slave.sv
// Memory responder for the CPU request path: 4-phase req/ack handshake,
// programmable wait states, word/byte access and odd-address error over a
// word-organised RAM window of 2^AW words starting at byte address BASE.
//   clk, reset : clock, synchronous active-high reset
//   req        : request, held until ack is seen
//   we         : 1 = write, 0 = read
//   bytew      : 1 = byte access, 0 = word access
//   addr       : byte address
//   d_in       : write data (byte writes use d_in[7:0])
//   d_out      : read/echo data, valid while ack=1, held otherwise
//   ack        : access complete
//   err        : odd-address word access (meaningful while ack=1)
module unibus_ram_slave
  import unibus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE = 16'o000000,
  parameter int unsigned       AW   = 12,
  parameter int unsigned       WAIT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic              bytew,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  output logic              ack,
  output logic              err
);

  localparam int unsigned WIN_BYTES = 32'd1 << (AW + 1);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT);
  localparam logic        NO_WAIT   = (WAIT == 0);

  state_t            r_state;
  logic [3:0]        r_wcnt;
  logic              r_ack;
  logic              r_err;
  logic [DATA_W-1:0] r_dout;
  logic              r_from_ram;
  logic [AW-1:0]     r_idx;
  logic              r_lane_hi;
  logic              r_byte_rd;

  logic [ADDR_W-1:0] w_off;
  logic              w_hit;
  logic              w_odd;
  logic              w_access;
  logic              w_do_ram;
  logic              w_we_lo;
  logic              w_we_hi;
  logic [AW-1:0]     w_widx;
  logic [AW-1:0]     w_ram_idx;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_ram_fmt;

  always_comb begin
    w_off  = addr - BASE;
    w_hit  = (32'(w_off) < WIN_BYTES);
    w_widx = w_off[AW:1];
    w_odd  = addr[0] & ~bytew;

    // Edge on which the access is performed and ack is raised.
    w_access = ~reset & req &
               (((r_state == S_IDLE) & w_hit & NO_WAIT) |
                ((r_state == S_WAIT) & (r_wcnt <= 4'd1)));

    w_do_ram = w_access & ~w_odd;
    w_we_lo  = w_do_ram & we & (~bytew | ~addr[0]);
    w_we_hi  = w_do_ram & we & (~bytew |  addr[0]);
    w_wdata  = bytew ? {d_in[7:0], d_in[7:0]} : d_in;

    // While ack is held the RAM keeps re-reading the latched index, so its
    // registered output stays equal to the completed access.
    w_ram_idx = (r_state == S_DONE) ? r_idx : w_widx;

    w_ram_fmt = r_byte_rd ? {8'h00, (r_lane_hi ? w_rdata[15:8] : w_rdata[7:0])}
                          : w_rdata;
  end

  ram_bytelane #(
    .AW(AW)
  ) u_ram (
    .clk   (clk),
    .idx   (w_ram_idx),
    .we_lo (w_we_lo),
    .we_hi (w_we_hi),
    .wdata (w_wdata),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wcnt     <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_dout     <= '0;
      r_from_ram <= 1'b0;
      r_idx      <= '0;
      r_lane_hi  <= 1'b0;
      r_byte_rd  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req && w_hit) begin
            r_wcnt  <= WAIT_INIT;
            r_state <= NO_WAIT ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!req) begin
            r_state <= S_IDLE;
            r_wcnt  <= '0;
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
            if (r_wcnt <= 4'd1) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!req) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            // Freeze the RAM-sourced value before the RAM index is released.
            if (r_from_ram) r_dout <= w_ram_fmt;
            r_from_ram <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_access) begin
        r_ack <= 1'b1;
        r_err <= w_odd;
        if (!w_odd) begin
          r_from_ram <= 1'b1;
          r_idx      <= w_widx;
          r_lane_hi  <= addr[0];
          r_byte_rd  <= bytew & ~we;
        end
      end
    end
  end

  // d_out is the RAM's output register while a successful access is
  // acknowledged, and the holding register otherwise; both are flops and the
  // select is a flop, so no combinational path from the inputs reaches d_out.
  assign d_out = r_from_ram ? w_ram_fmt : r_dout;
  assign ack   = r_ack;
  assign err   = r_err;

endmodule

// File: tb/tb_unibus_ram_slave.sv
// Testbench for unibus_ram_slave: three instances (WAIT = 2, 3, 0) sharing
// clock, reset and request fields, each with its own req. Table-driven
// vectors, hand-written multi-cycle sequences, then randomized traffic
// checked against a word-array reference model.
module tb_unibus_ram_slave;

  typedef struct {
    int          k;
    bit          we;
    bit          bw;
    logic [15:0] a;
    logic [15:0] d;
    bit          got;
    int          lat;
    bit          e;
    logic [15:0] dout;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic        bytew;
  logic [15:0] addr;
  logic [15:0] d_in;
  logic        req   [3];
  logic [15:0] d_out [3];
  logic        ack   [3];
  logic        err   [3];

  int total = 0;
  int bad   = 0;

  logic [15:0] mdl_mem  [3][4096];
  logic [15:0] mdl_last [3];
  vec_t        tv [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    unibus_ram_slave #(
      .BASE (16'o000000),
      .AW   (12),
      .WAIT ((g == 0) ? 2 : ((g == 1) ? 3 : 0))
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .req   (req[g]),
      .we    (we),
      .bytew (bytew),
      .addr  (addr),
      .d_in  (d_in),
      .d_out (d_out[g]),
      .ack   (ack[g]),
      .err   (err[g])
    );
  end

  function automatic int wait_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 3 : 0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference: window is byte addresses 0..8191, each word a plain array cell.
  task automatic model(input int k, input bit mwe, input bit mb, input logic [15:0] a,
                       input logic [15:0] d, output bit got, output int lat,
                       output bit e, output logic [15:0] dout);
    logic [11:0] idx;
    logic [15:0] w;
    got  = (a < 16'o020000);
    lat  = wait_of(k) + 1;
    e    = 1'b0;
    dout = mdl_last[k];
    if (got) begin
      if (!mb && a[0]) begin
        e = 1'b1;
      end else begin
        idx = a[12:1];
        w   = mdl_mem[k][idx];
        if (mwe) begin
          if (!mb)      w = d;
          else if (a[0]) w[15:8] = d[7:0];
          else           w[7:0]  = d[7:0];
          mdl_mem[k][idx] = w;
          dout = w;
        end else if (!mb) begin
          dout = w;
        end else begin
          dout = {8'h00, (a[0] ? w[15:8] : w[7:0])};
        end
        mdl_last[k] = dout;
      end
    end
  endtask

  // One full handshake on instance k; ack wait bounded at 25 clocks.
  task automatic xact(input int k, input bit iwe, input bit ib, input logic [15:0] ia,
                      input logic [15:0] id, input string nm, output bit got,
                      output int lat, output logic [15:0] od, output bit oe);
    @(posedge clk); #1;
    we = iwe; bytew = ib; addr = ia; d_in = id; req[k] = 1'b1;
    got = 1'b0; lat = 0;
    for (int i = 0; i < 25 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (ack[k] === 1'b1) got = 1'b1;
    end
    od = d_out[k];
    oe = err[k];
    req[k] = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_ackfall"}, 32'(ack[k]), 32'd0);
    chk({nm, "_dhold"}, 32'(d_out[k]), 32'(od));
  endtask

  task automatic run_op(input int k, input bit iwe, input bit ib, input logic [15:0] ia,
                        input logic [15:0] id, input string nm);
    bit eg, ag, ee, ae;
    int el, al;
    logic [15:0] ed, ad;
    model(k, iwe, ib, ia, id, eg, el, ee, ed);
    xact(k, iwe, ib, ia, id, nm, ag, al, ad, ae);
    chk({nm, "_ack"}, 32'(ag), 32'(eg));
    if (eg) begin
      chk({nm, "_lat"}, 32'(al), 32'(el));
      chk({nm, "_err"}, 32'(ae), 32'(ee));
    end
    chk({nm, "_dout"}, 32'(ad), 32'(ed));
  endtask

  task automatic add(input int k, input bit w, input bit b, input logic [15:0] a,
                     input logic [15:0] d, input bit g, input int l, input bit e,
                     input logic [15:0] o);
    vec_t v;
    v.k = k; v.we = w; v.bw = b; v.a = a; v.d = d;
    v.got = g; v.lat = l; v.e = e; v.dout = o;
    tv.push_back(v);
  endtask

  initial begin
    bit          g, e, sg, se;
    int          l, sl;
    logic [15:0] o, so;
    bit          seen;
    bit          stray;

    // instance 0: WAIT=2 -> 3 clocks; instance 1: WAIT=3 -> 4; instance 2: WAIT=0 -> 1
    add(0, 1, 0, 16'o000100, 16'o123456, 1, 3, 0, 16'o123456);
    add(0, 0, 0, 16'o000100, 16'o000000, 1, 3, 0, 16'o123456);
    add(0, 1, 0, 16'o000100, 16'o000123, 1, 3, 0, 16'o000123);
    add(0, 1, 1, 16'o000101, 16'o000377, 1, 3, 0, 16'o177523);
    add(0, 0, 0, 16'o000100, 16'o000000, 1, 3, 0, 16'o177523);
    add(0, 0, 1, 16'o000101, 16'o000000, 1, 3, 0, 16'o000377);
    add(0, 0, 1, 16'o000100, 16'o000000, 1, 3, 0, 16'o000123);
    add(0, 1, 0, 16'o000102, 16'o070707, 1, 3, 0, 16'o070707);
    add(0, 0, 0, 16'o000103, 16'o000000, 1, 3, 1, 16'o070707);
    add(0, 1, 0, 16'o000103, 16'o177777, 1, 3, 1, 16'o070707);
    add(0, 0, 0, 16'o000102, 16'o000000, 1, 3, 0, 16'o070707);
    add(0, 1, 1, 16'o000102, 16'hAB12,   1, 3, 0, 16'h7112);
    add(0, 0, 1, 16'o000103, 16'o000000, 1, 3, 0, 16'h0071);
    add(0, 1, 0, 16'o017776, 16'hBEEF,   1, 3, 0, 16'hBEEF);
    add(0, 0, 0, 16'o017776, 16'o000000, 1, 3, 0, 16'hBEEF);
    add(0, 0, 0, 16'o020000, 16'o000000, 0, 0, 0, 16'hBEEF);
    add(0, 0, 0, 16'o000100, 16'o000000, 1, 3, 0, 16'o177523);
    add(0, 1, 0, 16'o177776, 16'h5555,   0, 0, 0, 16'o177523);
    add(1, 1, 0, 16'o000200, 16'h1111,   1, 4, 0, 16'h1111);
    add(2, 1, 0, 16'o000000, 16'h0A0A,   1, 1, 0, 16'h0A0A);
    add(2, 1, 0, 16'o000002, 16'h1B1B,   1, 1, 0, 16'h1B1B);
    add(2, 1, 0, 16'o000004, 16'h2C2C,   1, 1, 0, 16'h2C2C);
    add(2, 1, 0, 16'o000006, 16'h3D3D,   1, 1, 0, 16'h3D3D);

    reset = 1'b1; we = 1'b0; bytew = 1'b0; addr = '0; d_in = '0;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0;
      mdl_last[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset%0d_ack", k), 32'(ack[k]), 32'd0);
      chk($sformatf("reset%0d_err", k), 32'(err[k]), 32'd0);
      chk($sformatf("reset%0d_dout", k), 32'(d_out[k]), 32'd0);
    end
    reset = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      model(tv[i].k, tv[i].we, tv[i].bw, tv[i].a, tv[i].d, sg, sl, se, so);
      xact(tv[i].k, tv[i].we, tv[i].bw, tv[i].a, tv[i].d, $sformatf("tv%0d", i), g, l, o, e);
      chk($sformatf("tv%0d_ack", i), 32'(g), 32'(tv[i].got));
      if (tv[i].got) begin
        chk($sformatf("tv%0d_lat", i), 32'(l), 32'(tv[i].lat));
        chk($sformatf("tv%0d_err", i), 32'(e), 32'(tv[i].e));
      end
      chk($sformatf("tv%0d_dout", i), 32'(o), 32'(tv[i].dout));
    end

    // Aborted write on WAIT=3: req drops one clock after rising.
    @(posedge clk); #1;
    we = 1'b1; bytew = 1'b0; addr = 16'o000200; d_in = 16'h2222; req[1] = 1'b1;
    @(posedge clk); #1;
    req[1] = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack[1] !== 1'b0) stray = 1'b1;
    end
    chk("abort_noack", 32'(stray), 32'd0);
    run_op(1, 0, 0, 16'o000200, 16'h0000, "abort_readback");

    // Reset while an odd-address error is being acknowledged.
    @(posedge clk); #1;
    we = 1'b0; bytew = 1'b0; addr = 16'o000103; req[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (ack[0] === 1'b1) seen = 1'b1;
    end
    chk("rstdone_pre_ack", 32'(seen), 32'd1);
    chk("rstdone_pre_err", 32'(err[0]), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rstdone_ack", 32'(ack[0]), 32'd0);
    chk("rstdone_err", 32'(err[0]), 32'd0);
    chk("rstdone_dout", 32'(d_out[0]), 32'd0);
    reset = 1'b0; req[0] = 1'b0;
    for (int k = 0; k < 3; k++) mdl_last[k] = '0;
    @(posedge clk); #1;
    run_op(0, 0, 0, 16'o000100, 16'h0000, "rstdone_ramkept");

    // Back-to-back WAIT=0 reads of consecutive words.
    for (int i = 0; i < 4; i++)
      run_op(2, 0, 0, 16'(2 * i), 16'h0000, $sformatf("b2b%0d", i));

    // Randomized traffic: seed words 0..15 on every instance, then mixed ops.
    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 16; w++)
        run_op(k, 1, 0, 16'(2 * w), 16'($urandom), $sformatf("seed%0d_%0d", k, w));
    for (int n = 0; n < 60; n++) begin
      int          rk;
      logic [15:0] ra;
      rk = int'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) ra = 16'o020000 + 16'(2 * $urandom_range(0, 200));
      else                           ra = 16'($urandom_range(0, 31));
      run_op(rk, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra,
             16'($urandom), $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
